// File: rtl/sde_trigger_pkg.sv
// sde_trigger_pkg: shared FSM state encodings for the trigger-side qualifiers.
package sde_trigger_pkg;
    typedef enum logic {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } qual_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
// Ports: CLK, RSTN (async active-low), clr (zero, then inc still applies), inc, q.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);
    // clr and inc together leave 1, so an event coincident with a clear is still counted
    always_ff @(posedge CLK or negedge RSTN)
        if (!RSTN)
            q <= '0;
        else if (clr)
            q <= WIDTH'(inc);
        else if (inc && q != '1)
            q <= q + 1'b1;
endmodule

// File: rtl/sync_2bit_qualifier.sv
// sync_2bit_qualifier: debounces a synchronized 2-bit code and keeps change/glitch/age statistics.
// Ports: CLK, RSTN (async active-low), SYNC_IN code, SNAP capture strobe, CLEAR counters;
//        STATE_OUT accepted code, RISE/FALL per-bit pulses, CHG_CNT0/1, GLITCH_CNT, AGE,
//        SNAP_* captured copies and SNAP_VALID pulse.
module sync_2bit_qualifier
    import sde_trigger_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int AGE_WIDTH   = 32
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic [1:0]           SYNC_IN,
    input  logic                 SNAP,
    input  logic                 CLEAR,
    output logic [1:0]           STATE_OUT,
    output logic [1:0]           RISE,
    output logic [1:0]           FALL,
    output logic [CNT_WIDTH-1:0] CHG_CNT0,
    output logic [CNT_WIDTH-1:0] CHG_CNT1,
    output logic [CNT_WIDTH-1:0] GLITCH_CNT,
    output logic [AGE_WIDTH-1:0] AGE,
    output logic [1:0]           SNAP_STATE,
    output logic [CNT_WIDTH-1:0] SNAP_CHG0,
    output logic [CNT_WIDTH-1:0] SNAP_CHG1,
    output logic [CNT_WIDTH-1:0] SNAP_GLITCH,
    output logic [AGE_WIDTH-1:0] SNAP_AGE,
    output logic                 SNAP_VALID
);
    qual_state_t state, state_nxt;
    logic [1:0] cand, cand_nxt, acc_code;
    logic [7:0] hold_cnt, hold_nxt;
    logic       accept, glitch, age_clr;

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        hold_nxt  = hold_cnt;
        accept    = 1'b0;
        glitch    = 1'b0;
        acc_code  = cand;
        if (state == STABLE) begin
            if (SYNC_IN != STATE_OUT) begin
                if (HOLD_CYCLES == 1) begin
                    accept   = 1'b1;
                    acc_code = SYNC_IN;
                end else begin
                    state_nxt = QUALIFY;
                    cand_nxt  = SYNC_IN;
                    hold_nxt  = 8'd1;
                end
            end
        end else if (SYNC_IN == cand) begin
            hold_nxt = hold_cnt + 8'd1;
            if (hold_nxt == 8'(HOLD_CYCLES)) begin
                accept    = 1'b1;
                state_nxt = STABLE;
                hold_nxt  = '0;
            end
        end else begin
            // any break in the candidate run is a glitch; a third code restarts qualification
            glitch   = 1'b1;
            cand_nxt = SYNC_IN;
            hold_nxt = 8'd1;
            if (SYNC_IN == STATE_OUT) begin
                state_nxt = STABLE;
                hold_nxt  = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN)
        if (!RSTN) begin
            state     <= STABLE;
            cand      <= '0;
            hold_cnt  <= '0;
            STATE_OUT <= '0;
            RISE      <= '0;
            FALL      <= '0;
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            hold_cnt  <= hold_nxt;
            STATE_OUT <= accept ? acc_code : STATE_OUT;
            RISE      <= accept ? acc_code & ~STATE_OUT : 2'b00;
            FALL      <= accept ? ~acc_code & STATE_OUT : 2'b00;
        end

    always_ff @(posedge CLK or negedge RSTN)
        if (!RSTN) begin
            SNAP_STATE  <= '0;
            SNAP_CHG0   <= '0;
            SNAP_CHG1   <= '0;
            SNAP_GLITCH <= '0;
            SNAP_AGE    <= '0;
            SNAP_VALID  <= 1'b0;
        end else begin
            SNAP_VALID <= SNAP;
            if (SNAP) begin
                SNAP_STATE  <= STATE_OUT;
                SNAP_CHG0   <= CHG_CNT0;
                SNAP_CHG1   <= CHG_CNT1;
                SNAP_GLITCH <= GLITCH_CNT;
                SNAP_AGE    <= AGE;
            end
        end

    // age restarts at 0 on acceptance or clear, so its increment is suppressed on those edges
    assign age_clr = accept | CLEAR;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_chg0 (
        .CLK(CLK), .RSTN(RSTN), .clr(CLEAR),
        .inc(accept & (acc_code[0] ^ STATE_OUT[0])), .q(CHG_CNT0)
    );
    sat_counter #(.WIDTH(CNT_WIDTH)) u_chg1 (
        .CLK(CLK), .RSTN(RSTN), .clr(CLEAR),
        .inc(accept & (acc_code[1] ^ STATE_OUT[1])), .q(CHG_CNT1)
    );
    sat_counter #(.WIDTH(CNT_WIDTH)) u_glitch (
        .CLK(CLK), .RSTN(RSTN), .clr(CLEAR), .inc(glitch), .q(GLITCH_CNT)
    );
    sat_counter #(.WIDTH(AGE_WIDTH)) u_age (
        .CLK(CLK), .RSTN(RSTN), .clr(age_clr), .inc(~age_clr), .q(AGE)
    );
endmodule

// File: tb/tb_sync_2bit_qualifier.sv
// tb_sync_2bit_qualifier: table, directed and random checks of sync_2bit_qualifier against a history model.
module tb_sync_2bit_qualifier;
    localparam int H    = 4;
    localparam int CW   = 4;
    localparam int AW   = 8;
    localparam int CMAX = 15;
    localparam int AMAX = 255;

    logic          CLK, RSTN, SNAP, CLEAR;
    logic [1:0]    SYNC_IN, STATE_OUT, RISE, FALL, SNAP_STATE;
    logic [CW-1:0] CHG_CNT0, CHG_CNT1, GLITCH_CNT, SNAP_CHG0, SNAP_CHG1, SNAP_GLITCH;
    logic [AW-1:0] AGE, SNAP_AGE;
    logic          SNAP_VALID;

    sync_2bit_qualifier #(.HOLD_CYCLES(H), .CNT_WIDTH(CW), .AGE_WIDTH(AW)) dut (
        .CLK(CLK), .RSTN(RSTN), .SYNC_IN(SYNC_IN), .SNAP(SNAP), .CLEAR(CLEAR),
        .STATE_OUT(STATE_OUT), .RISE(RISE), .FALL(FALL),
        .CHG_CNT0(CHG_CNT0), .CHG_CNT1(CHG_CNT1), .GLITCH_CNT(GLITCH_CNT), .AGE(AGE),
        .SNAP_STATE(SNAP_STATE), .SNAP_CHG0(SNAP_CHG0), .SNAP_CHG1(SNAP_CHG1),
        .SNAP_GLITCH(SNAP_GLITCH), .SNAP_AGE(SNAP_AGE), .SNAP_VALID(SNAP_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // reference model: accepted code changes when the last H samples since reset all equal a new code
    logic [1:0] hist[$];
    logic [1:0] m_state, m_rise, m_fall, m_sst;
    int         m_c0, m_c1, m_gl, m_age, m_s0, m_s1, m_sg, m_sa;
    bit         m_sv;

    typedef struct {
        logic [1:0] sync;
        logic [1:0] st, ri, fa;
        int         c0, c1, gl, age;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat_next(input int old, input bit clr, input bit inc, input int mx);
        return clr ? int'(inc) : ((old + int'(inc) > mx) ? mx : old + int'(inc));
    endfunction

    task automatic model_reset();
        hist.delete();
        m_state = 0; m_rise = 0; m_fall = 0; m_sst = 0;
        m_c0 = 0; m_c1 = 0; m_gl = 0; m_age = 0;
        m_s0 = 0; m_s1 = 0; m_sg = 0; m_sa = 0; m_sv = 0;
    endtask

    task automatic model_step(input logic [1:0] c, input bit sn, input bit cl);
        logic [1:0] s, p, d;
        bit hp, acc, gl;
        s  = m_state;
        hp = hist.size() > 0;
        p  = hp ? hist[$] : 2'b00;
        if (sn) begin
            m_sst = m_state; m_s0 = m_c0; m_s1 = m_c1; m_sg = m_gl; m_sa = m_age;
        end
        m_sv = sn;
        hist.push_back(c);
        if (hist.size() > H) void'(hist.pop_front());
        acc = (c != s) && (hist.size() == H);
        foreach (hist[i]) if (hist[i] != c) acc = 0;
        gl  = hp && (p != s) && (c != p);
        d   = acc ? (c ^ s) : 2'b00;
        m_rise  = acc ? (c & ~s) : 2'b00;
        m_fall  = acc ? (~c & s) : 2'b00;
        m_state = acc ? c : s;
        m_c0  = sat_next(m_c0, cl, d[0], CMAX);
        m_c1  = sat_next(m_c1, cl, d[1], CMAX);
        m_gl  = sat_next(m_gl, cl, gl, CMAX);
        m_age = (acc || cl) ? 0 : ((m_age + 1 > AMAX) ? AMAX : m_age + 1);
    endtask

    task automatic compare_all();
        chk("state",       32'(STATE_OUT),   32'(m_state));
        chk("rise",        32'(RISE),        32'(m_rise));
        chk("fall",        32'(FALL),        32'(m_fall));
        chk("chg0",        32'(CHG_CNT0),    32'(m_c0));
        chk("chg1",        32'(CHG_CNT1),    32'(m_c1));
        chk("glitch",      32'(GLITCH_CNT),  32'(m_gl));
        chk("age",         32'(AGE),         32'(m_age));
        chk("snap_state",  32'(SNAP_STATE),  32'(m_sst));
        chk("snap_chg0",   32'(SNAP_CHG0),   32'(m_s0));
        chk("snap_chg1",   32'(SNAP_CHG1),   32'(m_s1));
        chk("snap_glitch", 32'(SNAP_GLITCH), 32'(m_sg));
        chk("snap_age",    32'(SNAP_AGE),    32'(m_sa));
        chk("snap_valid",  32'(SNAP_VALID),  32'(m_sv));
    endtask

    task automatic step(input logic [1:0] s, input bit sn, input bit cl);
        SYNC_IN = s; SNAP = sn; CLEAR = cl;
        @(posedge CLK);
        #1;
        model_step(s, sn, cl);
        compare_all();
    endtask

    task automatic add(input logic [1:0] sy, input logic [1:0] st, input logic [1:0] ri, input logic [1:0] fa,
                       input int c0, input int c1, input int gl, input int age);
        vec_t v;
        v.sync = sy; v.st = st; v.ri = ri; v.fa = fa; v.c0 = c0; v.c1 = c1; v.gl = gl; v.age = age;
        tbl.push_back(v);
    endtask

    logic [1:0] cur, r;

    initial begin
        // sync, state, rise, fall, chg0, chg1, glitch, age after the edge
        add(2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
        add(2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2);
        add(2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 3);
        add(2'b01, 2'b01, 2'b01, 2'b00, 1, 0, 0, 0);
        add(2'b01, 2'b01, 2'b00, 2'b00, 1, 0, 0, 1);
        add(2'b01, 2'b01, 2'b00, 2'b00, 1, 0, 0, 2);
        add(2'b00, 2'b01, 2'b00, 2'b00, 1, 0, 0, 3);
        add(2'b00, 2'b01, 2'b00, 2'b00, 1, 0, 0, 4);
        add(2'b00, 2'b01, 2'b00, 2'b00, 1, 0, 0, 5);
        add(2'b01, 2'b01, 2'b00, 2'b00, 1, 0, 1, 6);
        add(2'b11, 2'b01, 2'b00, 2'b00, 1, 0, 1, 7);
        add(2'b11, 2'b01, 2'b00, 2'b00, 1, 0, 1, 8);
        add(2'b11, 2'b01, 2'b00, 2'b00, 1, 0, 1, 9);
        add(2'b11, 2'b11, 2'b10, 2'b00, 1, 1, 1, 0);
        add(2'b00, 2'b11, 2'b00, 2'b00, 1, 1, 1, 1);
        add(2'b00, 2'b11, 2'b00, 2'b00, 1, 1, 1, 2);
        add(2'b00, 2'b11, 2'b00, 2'b00, 1, 1, 1, 3);
        add(2'b00, 2'b00, 2'b00, 2'b11, 2, 2, 1, 0);
        add(2'b11, 2'b00, 2'b00, 2'b00, 2, 2, 1, 1);
        add(2'b11, 2'b00, 2'b00, 2'b00, 2, 2, 1, 2);
        add(2'b11, 2'b00, 2'b00, 2'b00, 2, 2, 1, 3);
        add(2'b11, 2'b11, 2'b11, 2'b00, 3, 3, 1, 0);
        add(2'b11, 2'b11, 2'b00, 2'b00, 3, 3, 1, 1);

        RSTN = 1'b0; SYNC_IN = 2'b00; SNAP = 1'b0; CLEAR = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_state", 32'(STATE_OUT), 32'd0);
        chk("reset_age", 32'(AGE), 32'd0);
        chk("reset_snap_valid", 32'(SNAP_VALID), 32'd0);
        RSTN = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].sync, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_state", i), 32'(STATE_OUT), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_rise", i), 32'(RISE), 32'(tbl[i].ri));
            chk($sformatf("tbl%0d_fall", i), 32'(FALL), 32'(tbl[i].fa));
            chk($sformatf("tbl%0d_chg0", i), 32'(CHG_CNT0), 32'(tbl[i].c0));
            chk($sformatf("tbl%0d_chg1", i), 32'(CHG_CNT1), 32'(tbl[i].c1));
            chk($sformatf("tbl%0d_glitch", i), 32'(GLITCH_CNT), 32'(tbl[i].gl));
            chk($sformatf("tbl%0d_age", i), 32'(AGE), 32'(tbl[i].age));
        end
        cur = 2'b11;

        // five bit-0 toggles after a clear, then snapshot+clear on the sixth acceptance edge
        step(cur, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cur = cur ^ 2'b01;
            repeat (H) step(cur, 1'b0, 1'b0);
            if (k == 0) begin
                chk("fall_11_to_10", 32'(FALL), 32'd1);
                chk("chg0_after_first_toggle", 32'(CHG_CNT0), 32'd1);
            end
        end
        chk("chg0_before_snap", 32'(CHG_CNT0), 32'd5);
        cur = cur ^ 2'b01;
        repeat (H - 1) step(cur, 1'b0, 1'b0);
        step(cur, 1'b1, 1'b1);
        chk("snap_chg0_preclear", 32'(SNAP_CHG0), 32'd5);
        chk("chg0_clear_plus_event", 32'(CHG_CNT0), 32'd1);
        chk("snap_valid_pulse", 32'(SNAP_VALID), 32'd1);
        chk("age_on_accept_clear", 32'(AGE), 32'd0);
        step(cur, 1'b0, 1'b0);
        chk("snap_valid_drop", 32'(SNAP_VALID), 32'd0);

        // saturation of the change counter and of age
        step(cur, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            cur = cur ^ 2'b01;
            repeat (H) step(cur, 1'b0, 1'b0);
        end
        chk("chg0_saturated", 32'(CHG_CNT0), 32'd15);
        chk("chg1_untouched", 32'(CHG_CNT1), 32'd0);
        repeat (260) step(cur, 1'b0, 1'b0);
        chk("age_saturated", 32'(AGE), 32'd255);

        // asynchronous reset in the middle of qualification
        repeat (H - 1) step(cur ^ 2'b11, 1'b0, 1'b0);
        #2 RSTN = 1'b0;
        #1;
        chk("rst_state", 32'(STATE_OUT), 32'd0);
        chk("rst_chg0", 32'(CHG_CNT0), 32'd0);
        chk("rst_age", 32'(AGE), 32'd0);
        chk("rst_snap_chg0", 32'(SNAP_CHG0), 32'd0);
        chk("rst_snap_state", 32'(SNAP_STATE), 32'd0);
        model_reset();
        #1 RSTN = 1'b1;
        for (int k = 0; k < H; k++) begin
            step(2'b01, 1'b0, 1'b0);
            chk($sformatf("post_rst_state%0d", k), 32'(STATE_OUT), (k == H - 1) ? 32'd1 : 32'd0);
        end

        // randomized traffic with sticky codes so that acceptances and glitches both occur
        r = 2'b01;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(9) < 3) r = 2'($urandom_range(3));
            step(r, $urandom_range(9) == 0, $urandom_range(19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
